// File: rtl/width_downconv_fifo.sv
// Word-in / slice-out FIFO: stores IN_W-bit words, emits OUT_W-bit slices
// with a registered one-cycle read latency and sticky over/underflow flags.
module width_downconv_fifo #(
   parameter int IN_W      = 16,
   parameter int OUT_W     = 1,
   parameter int DEPTH     = 64,
   parameter int MSB_FIRST = 1
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [IN_W-1:0]                             din,
   input  logic                                        wr_en,
   input  logic                                        rd_en,
   output logic [OUT_W-1:0]                            dout,
   output logic                                        full,
   output logic                                        empty,
   output logic [$clog2(DEPTH*(IN_W/OUT_W)+1)-1:0]     count,
   output logic                                        overflow,
   output logic                                        underflow
);

   localparam int RATIO = IN_W / OUT_W;
   localparam int CW    = $clog2(DEPTH*RATIO+1);
   localparam int AW    = $clog2(DEPTH);
   localparam int WCW   = $clog2(DEPTH+1);
   localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [IN_W-1:0]  mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [SW-1:0]    slice_q, slice_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic [OUT_W-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             wr_ok, rd_ok, last;
   logic [IN_W-1:0]  word;
   logic [OUT_W-1:0] slice;

   // Flags come straight from registered state, never from same-cycle requests.
   assign full  = (wcnt_q == WCW'(DEPTH));
   assign empty = (count_q == '0);

   assign wr_ok = wr_en & ~full & ~rst;
   assign rd_ok = rd_en & ~empty & ~rst;
   assign last  = (slice_q == SW'(RATIO-1));

   assign word = mem_q[rptr_q];

   always_comb begin
      slice = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (slice_q == SW'(k)) begin
            slice = (MSB_FIRST != 0) ? word[IN_W-1-k*OUT_W -: OUT_W]
                                     : word[k*OUT_W +: OUT_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wptr_q] <= din;
      end
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      slice_d = slice_q;
      dout_d  = dout_q;
      count_d = count_q + (wr_ok ? CW'(RATIO) : '0)
                        - (rd_ok ? CW'(1) : '0);
      wcnt_d  = wcnt_q + (wr_ok ? WCW'(1) : '0)
                       - ((rd_ok && last) ? WCW'(1) : '0);
      ovf_d   = ovf_q | (wr_en & full);
      unf_d   = unf_q | (rd_en & empty);
      if (wr_ok) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (rd_ok) begin
         dout_d = slice;
         if (last) begin
            slice_d = '0;
            rptr_d  = rptr_q + AW'(1);
         end else begin
            slice_d = slice_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         slice_q <= '0;
         count_q <= '0;
         wcnt_q  <= '0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         slice_q <= slice_d;
         count_q <= count_d;
         wcnt_q  <= wcnt_d;
         dout_q  <= dout_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign dout      = dout_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_width_downconv_fifo.sv
// Directed bench for width_downconv_fifo: 16->1 default instance plus a
// 16->4 LSB-first instance, with a bit-queue scoreboard for long streams.
module tb_width_downconv_fifo;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, wr_en, rd_en;
   logic [15:0] din;
   logic [0:0]  dout;
   logic        full, empty, overflow, underflow;
   logic [10:0] count;

   logic        rst4, wr4, rd4;
   logic [15:0] din4;
   logic [3:0]  dout4;
   logic        full4, empty4, ovf4, unf4;
   logic [8:0]  count4;

   width_downconv_fifo u_dut (
      .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
      .dout(dout), .full(full), .empty(empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   width_downconv_fifo #(.IN_W(16), .OUT_W(4), .DEPTH(64), .MSB_FIRST(0)) u_dut4 (
      .clk(clk), .rst(rst4), .din(din4), .wr_en(wr4), .rd_en(rd4),
      .dout(dout4), .full(full4), .empty(empty4), .count(count4),
      .overflow(ovf4), .underflow(unf4)
   );

   int ncmp = 0;
   int nerr = 0;
   bit q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle on the default instance, tracked by the bit-queue model.
   task automatic mstep(input logic w, input logic [15:0] d, input logic r);
      int words;
      bit acc_w, acc_r, eb;
      words = (q.size() + 15) / 16;
      acc_w = w && (words < 64);
      acc_r = r && (q.size() > 0);
      wr_en = w; din = d; rd_en = r;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      if (acc_r) begin
         eb = q.pop_front();
         chk("sb_dout", 32'(dout), 32'(eb));
      end
      if (acc_w) for (int i = 15; i >= 0; i--) q.push_back(d[i]);
      chk("sb_count", 32'(count), 32'(q.size()));
   endtask

   logic [15:0] exp031;
   logic [3:0]  exp032 [4];

   initial begin
      exp031 = 16'b1010_0101_1100_0011;
      exp032 = '{4'h4, 4'h3, 4'h2, 4'h1};
      // Reset with requests held high: they must be ignored.
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 16'hFFFF;
      rst4 = 1'b1; wr4 = 1'b0; rd4 = 1'b0; din4 = '0;
      tick(); tick();
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      rst4 = 1'b0;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_unf", 32'(underflow), 32'd0);

      // A5C3 serialised MSB first
      wr_en = 1'b1; din = 16'hA5C3; tick(); wr_en = 1'b0;
      chk("a5_count", 32'(count), 32'd16);
      chk("a5_empty", 32'(empty), 32'd0);
      for (int k = 0; k < 16; k++) begin
         rd_en = 1'b1; tick();
         chk("a5_dout", 32'(dout), 32'(exp031[15-k]));
         chk("a5_cnt", 32'(count), 32'(15-k));
      end
      rd_en = 1'b0;
      chk("a5_empty_end", 32'(empty), 32'd1);

      // Underflow: plain read, then read with a same-cycle write
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      chk("unf_flag", 32'(underflow), 32'd1);
      chk("unf_dout", 32'(dout), 32'd1);
      chk("unf_count", 32'(count), 32'd0);
      rd_en = 1'b1; wr_en = 1'b1; din = 16'hFFFF; tick();
      rd_en = 1'b0; wr_en = 1'b0;
      chk("unf_wr_count", 32'(count), 32'd16);
      chk("unf_wr_dout", 32'(dout), 32'd1);
      chk("unf_sticky", 32'(underflow), 32'd1);

      // Simultaneous write/read from count=5
      for (int k = 0; k < 11; k++) begin
         rd_en = 1'b1; tick();
      end
      rd_en = 1'b0;
      chk("cnt5", 32'(count), 32'd5);
      wr_en = 1'b1; rd_en = 1'b1; din = 16'h1234; tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("cnt20", 32'(count), 32'd20);

      rst = 1'b1; tick(); rst = 1'b0;
      q.delete();
      chk("rst2_count", 32'(count), 32'd0);
      chk("rst2_unf", 32'(underflow), 32'd0);

      // Fill to full, overflow, free one word, refill
      for (int i = 0; i < 64; i++) mstep(1'b1, 16'(i*16'h0123) ^ 16'h5A5A, 1'b0);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd1024);
      mstep(1'b1, 16'hDEAD, 1'b0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd1024);
      mstep(1'b1, 16'hBEEF, 1'b1);
      chk("ovf_rd_count", 32'(count), 32'd1023);
      chk("ovf_rd_full", 32'(full), 32'd1);
      for (int i = 0; i < 15; i++) mstep(1'b0, 16'h0, 1'b1);
      chk("freed_full", 32'(full), 32'd0);
      mstep(1'b1, 16'h7E57, 1'b0);
      chk("refill_full", 32'(full), 32'd1);
      chk("refill_count", 32'(count), 32'd1024);

      // Drain to bring the read pointer near its wrap, then mixed traffic
      for (int i = 0; i < 992; i++) mstep(1'b0, 16'h0, 1'b1);
      chk("drain_count", 32'(count), 32'd32);
      for (int i = 0; i < 200; i++) begin
         mstep(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      chk("mix_empty", 32'(empty), 32'(q.size() == 0));

      // Reset discards a partially read word
      rst = 1'b1; tick(); rst = 1'b0;
      q.delete();
      wr_en = 1'b1; din = 16'h1234; tick();
      din = 16'hABCD; tick(); wr_en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         rd_en = 1'b1; tick();
      end
      rd_en = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd25);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("r36_empty", 32'(empty), 32'd1);
      chk("r36_count", 32'(count), 32'd0);
      chk("r36_full", 32'(full), 32'd0);
      chk("r36_ovf", 32'(overflow), 32'd0);
      chk("r36_unf", 32'(underflow), 32'd0);
      chk("r36_dout", 32'(dout), 32'd0);
      wr_en = 1'b1; din = 16'h8001; tick(); wr_en = 1'b0;
      chk("r36_wr_count", 32'(count), 32'd16);
      rd_en = 1'b1; tick();
      chk("r36_first", 32'(dout), 32'd1);
      tick(); rd_en = 1'b0;
      chk("r36_second", 32'(dout), 32'd0);
      chk("r36_cnt14", 32'(count), 32'd14);

      // 16->4 LSB-first instance
      wr4 = 1'b1; din4 = 16'h1234; tick(); wr4 = 1'b0;
      chk("w4_count", 32'(count4), 32'd4);
      for (int k = 0; k < 4; k++) begin
         rd4 = 1'b1; tick();
         chk("w4_dout", 32'(dout4), 32'(exp032[k]));
         chk("w4_cnt", 32'(count4), 32'(3-k));
      end
      rd4 = 1'b0;
      chk("w4_empty", 32'(empty4), 32'd1);
      chk("w4_unf", 32'(unf4), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
